audio_tone_detector: RTL and testbench
======================================

// Module: audio_tone_detector
// PURPOSE
//  Audio-input decoder for the square-wave tone path. Each note code c (0..15) is played as a square
//  wave whose half-period is c*2^15+3001 CLOCK_50 cycles. This block consumes ADC samples from
//  Audio_Controller (audio_in_available / read_audio_in / left_channel_audio_in), measures the
//  half-period between hysteretic zero crossings, and recovers the 4-bit note code.
// PARAMETERS
//  THRESH         32'sd5000000  hysteresis level; a sample > +THRESH is high, a sample < -THRESH is low
//  OFFSET         3001          constant half-period component, in cycles
//  STEP_LOG2      15            log2 of the half-period step per note code
//  STABLE_COUNT   3             consecutive identical codes required to lock (range 1..7)
//  TIMEOUT_CYCLES 24'd600000    cycles with no crossing before signal loss
// PORTS
//  CLOCK_50               in   1   system clock, 50 MHz
//  resetn                 in   1   synchronous reset, active-low
//  audio_in_available     in   1   Audio_Controller has a sample pair ready
//  left_channel_audio_in  in   32  signed left sample
//  right_channel_audio_in in   32  signed right sample; used only with DETECT_STEREO_EN
//  read_audio_in          out  1   consume sample (combinational: audio_in_available & resetn)
//  note_code              out  4   locked note code
//  note_valid             out  1   level; note_code is locked and current
//  note_strobe            out  1   1-cycle pulse on first lock or on a change of locked code
//  half_period            out  24  most recent measured half-period, in cycles
// BEHAVIOUR
//  - Reset (resetn=0 at posedge): all outputs 0 except read_audio_in, which is combinationally 0.
//    state=UNARMED, cycle counter=0, match count=0. A reset mid-lock drops the lock at the same edge.
//  - Sample capture: on each edge with read_audio_in=1, the sample s is registered.
//    The classification of s takes effect on the next edge (one-cycle latency).
//  - Cycle counter: 24-bit. Counts cycles since the last crossing. Saturates at TIMEOUT_CYCLES.
//    Set to 1 on the edge a crossing is accepted.
//  - FSM states UNARMED, HIGH, LOW:
//     UNARMED: s>THRESH -> HIGH; s<-THRESH -> LOW. Counter is zeroed. No measurement is taken.
//     HIGH: s<-THRESH -> LOW (crossing). LOW: s>THRESH -> HIGH (crossing).
//     Samples in [-THRESH, THRESH] leave the state unchanged. Comparisons are 32-bit signed.
//  - On a crossing: hp = counter value; half_period <= hp.
//    code = (hp + 2^(STEP_LOG2-1) - OFFSET) >> STEP_LOG2, computed in 26-bit unsigned arithmetic.
//    If hp + 2^(STEP_LOG2-1) < OFFSET, code = 0. If the result is > 15, code = 15.
//  - Lock logic:
//     if code == cand: match = min(match+1, STABLE_COUNT); else cand = code and match = 1.
//     When match reaches STABLE_COUNT and (note_valid==0 or cand != note_code):
//     note_code <= cand, note_valid <= 1, note_strobe <= 1 for exactly 1 cycle.
//  - Timeout: when the counter reaches TIMEOUT_CYCLES -> state UNARMED, note_valid=0, note_code=0,
//    match=0; no strobe. If a crossing and the timeout occur on the same edge, the crossing wins.
//  - Back-to-back samples (audio_in_available held high) are consumed one per cycle.
// CONFIGURATION
//  DETECT_STEREO_EN defined: s = (left + right) >>> 1, with a 33-bit signed sum and an arithmetic shift.
//  Not defined: s = left_channel_audio_in; right_channel_audio_in is ignored.
//  Port list is identical in both builds.
// TESTING
//  1 resetn=0 for 2 cycles with audio_in_available=1 -> read_audio_in=0; note_*, half_period all 0.
//  2 +/-10000000 square wave, half-period 166841 cycles, one sample per 1000 cycles
//    -> after the 3rd post-arm crossing: note_code=5, note_valid=1, exactly one note_strobe.
//  3 From the test-2 lock, switch to half-period 297913 -> code 9 locks after 3 crossings, one strobe.
//    note_valid stays 1 throughout.
//  4 +/-1000000 input (inside hysteresis) -> no crossings; 600000 cycles after the last crossing
//    note_valid=0 and note_code=0.
//  5 Half-period 540000 -> computed code 16 saturates to 15; note_code=15 locks.
//  6 Lock on code 5, then resetn=0 for 1 cycle mid-tone -> all outputs 0; relock after 1 arming
//    transition plus 3 crossings.

Source files
------------

// File: rtl/audio_tone_detector.sv
// Square-wave tone decoder: hysteretic zero-crossing half-period measurement mapped to a 4-bit note code.
// Optional macro DETECT_STEREO_EN: detect on (left + right) >>> 1 instead of the left channel alone.
module audio_tone_detector #(
  parameter logic signed [31:0] THRESH         = 32'sd5000000,
  parameter int unsigned        OFFSET         = 3001,
  parameter int unsigned        STEP_LOG2      = 15,
  parameter int unsigned        STABLE_COUNT   = 3,
  parameter logic [23:0]        TIMEOUT_CYCLES = 24'd600000
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        audio_in_available,
  input  logic [31:0] left_channel_audio_in,
  input  logic [31:0] right_channel_audio_in,
  output logic        read_audio_in,
  output logic [3:0]  note_code,
  output logic        note_valid,
  output logic        note_strobe,
  output logic [23:0] half_period
);

  localparam int unsigned CNT_W   = 24;
  localparam int unsigned CODE_W  = 4;
  localparam int unsigned MATCH_W = 3;
  localparam int unsigned CALC_W  = 26;
  localparam logic [CALC_W-1:0]  HALF_STEP  = CALC_W'(2 ** (STEP_LOG2 - 1));
  localparam logic [CALC_W-1:0]  OFFSET_C   = CALC_W'(OFFSET);
  localparam logic [MATCH_W-1:0] STABLE_C   = MATCH_W'(STABLE_COUNT);
  localparam logic signed [31:0] NEG_THRESH = -THRESH;

  typedef enum logic [1:0] {ST_UNARMED, ST_HIGH, ST_LOW} state_t;

  state_t                   state_q, state_d;
  logic signed [31:0]       sample_q, sample_d, samp_sel;
  logic                     svld_q, svld_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]         hp_q, hp_d;
  logic [CODE_W-1:0]        cand_q, cand_d;
  logic [MATCH_W-1:0]       match_q, match_d;
  logic [CODE_W-1:0]        code_q, code_d;
  logic                     valid_q, valid_d;
  logic                     strobe_q, strobe_d;
  logic [CALC_W-1:0]        calc_sum, calc_q;
  logic [CODE_W-1:0]        code_calc;
  logic                     is_hi, is_lo, crossing;

`ifdef DETECT_STEREO_EN
  logic signed [32:0] stereo_sum;
  assign stereo_sum = {left_channel_audio_in[31], left_channel_audio_in}
                    + {right_channel_audio_in[31], right_channel_audio_in};
  assign samp_sel   = stereo_sum[32:1];
`else
  logic unused_right;
  assign unused_right = ^right_channel_audio_in;
  assign samp_sel     = left_channel_audio_in;
`endif

  assign read_audio_in = audio_in_available & resetn;

  // Rounded half-period to note code, clamped to 0..15
  always_comb begin
    calc_q    = '0;
    code_calc = '0;
    calc_sum  = CALC_W'(cnt_q) + HALF_STEP;
    if (calc_sum >= OFFSET_C) begin
      calc_q    = (calc_sum - OFFSET_C) >> STEP_LOG2;
      code_calc = (calc_q > CALC_W'(15)) ? 4'hF : calc_q[3:0];
    end
  end

  assign is_hi = svld_q && (sample_q > THRESH);
  assign is_lo = svld_q && (sample_q < NEG_THRESH);

  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    svld_d   = read_audio_in;
    cnt_d    = cnt_q;
    hp_d     = hp_q;
    cand_d   = cand_q;
    match_d  = match_q;
    code_d   = code_q;
    valid_d  = valid_q;
    strobe_d = 1'b0;
    crossing = 1'b0;
    if (read_audio_in) sample_d = samp_sel;

    case (state_q)
      ST_UNARMED: begin
        cnt_d = '0;
        if (is_hi)      state_d = ST_HIGH;
        else if (is_lo) state_d = ST_LOW;
      end
      ST_HIGH: if (is_lo) begin
        state_d  = ST_LOW;
        crossing = 1'b1;
      end
      ST_LOW: if (is_hi) begin
        state_d  = ST_HIGH;
        crossing = 1'b1;
      end
      default: state_d = ST_UNARMED;
    endcase

    // Crossing takes priority over timeout on the same edge
    if (state_q != ST_UNARMED) begin
      if (crossing) begin
        cnt_d = CNT_W'(1);
        hp_d  = cnt_q;
        if (code_calc == cand_q) begin
          match_d = (match_q >= STABLE_C) ? STABLE_C : match_q + 3'd1;
        end else begin
          cand_d  = code_calc;
          match_d = 3'd1;
        end
        if ((match_d == STABLE_C) && (!valid_q || (cand_d != code_q))) begin
          code_d   = cand_d;
          valid_d  = 1'b1;
          strobe_d = 1'b1;
        end
      end else if (cnt_q == TIMEOUT_CYCLES) begin
        state_d = ST_UNARMED;
        cnt_d   = '0;
        valid_d = 1'b0;
        code_d  = '0;
        match_d = '0;
      end else begin
        cnt_d = cnt_q + 24'd1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q  <= ST_UNARMED;
      sample_q <= '0;
      svld_q   <= 1'b0;
      cnt_q    <= '0;
      hp_q     <= '0;
      cand_q   <= '0;
      match_q  <= '0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      svld_q   <= svld_d;
      cnt_q    <= cnt_d;
      hp_q     <= hp_d;
      cand_q   <= cand_d;
      match_q  <= match_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
    end
  end

  assign note_code   = code_q;
  assign note_valid  = valid_q;
  assign note_strobe = strobe_q;
  assign half_period = hp_q;

endmodule

// File: tb/tb_audio_tone_detector.sv
// Directed bench for audio_tone_detector, scaled timing: OFFSET=30, step 32 cycles, timeout 2000 cycles.
module tb_audio_tone_detector;

  localparam int unsigned TB_OFFSET  = 30;
  localparam int unsigned TB_STEP    = 5;
  localparam logic [23:0] TB_TIMEOUT = 24'd2000;
  localparam int          AMP_BIG    = 10000000;
  localparam int          AMP_SMALL  = 1000000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        audio_in_available;
  logic [31:0] left_in, right_in;
  logic        read_audio_in;
  logic [3:0]  note_code;
  logic        note_valid, note_strobe;
  logic [23:0] half_period;

  int n_checks = 0;
  int n_fail   = 0;
  int strobe_total = 0;
  bit pol = 1'b1;

  always #5 clk = ~clk;

  audio_tone_detector #(
    .THRESH(32'sd5000000), .OFFSET(TB_OFFSET), .STEP_LOG2(TB_STEP),
    .STABLE_COUNT(3), .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .CLOCK_50(clk), .resetn(resetn), .audio_in_available(audio_in_available),
    .left_channel_audio_in(left_in), .right_channel_audio_in(right_in),
    .read_audio_in(read_audio_in), .note_code(note_code), .note_valid(note_valid),
    .note_strobe(note_strobe), .half_period(half_period)
  );

  always @(negedge clk) if (note_strobe === 1'b1) strobe_total <= strobe_total + 1;

  typedef struct {
    int          p;
    int          nhalf;
    logic [3:0]  code;
    logic        valid;
    logic [23:0] hp;
    int          strobes;
  } vec_t;

  vec_t tbl[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Square wave: each half-period holds one level for p cycles, one sample per cycle
  task automatic play(input int p, input int amp, input int nhalf, output int inval);
    inval = 0;
    for (int h = 0; h < nhalf; h++) begin
      left_in = pol ? 32'(amp) : 32'(-amp);
      for (int c = 0; c < p; c++) begin
        tick();
        if (note_valid !== 1'b1) inval++;
      end
      pol = ~pol;
    end
  endtask

  initial begin
    int base;
    int inval;

    // half-period -> code: 190->5, 318->9, 542->16 sat 15, 10->0 (below offset), 78->2, 77->1
    tbl[0] = '{p: 190, nhalf: 4, code: 4'd5,  valid: 1'b1, hp: 24'd190, strobes: 1};
    tbl[1] = '{p: 318, nhalf: 4, code: 4'd9,  valid: 1'b1, hp: 24'd318, strobes: 1};
    tbl[2] = '{p: 542, nhalf: 4, code: 4'd15, valid: 1'b1, hp: 24'd542, strobes: 1};
    tbl[3] = '{p: 10,  nhalf: 4, code: 4'd0,  valid: 1'b1, hp: 24'd10,  strobes: 1};
    tbl[4] = '{p: 78,  nhalf: 4, code: 4'd2,  valid: 1'b1, hp: 24'd78,  strobes: 1};
    tbl[5] = '{p: 77,  nhalf: 4, code: 4'd1,  valid: 1'b1, hp: 24'd77,  strobes: 1};

    resetn = 1'b0;
    audio_in_available = 1'b1;
    left_in  = 32'(AMP_BIG);
    right_in = 32'h1234_5678;
    tick();
    tick();
    check("reset_read", 32'(read_audio_in), 32'd0);
    check("reset_code", 32'(note_code), 32'd0);
    check("reset_valid", 32'(note_valid), 32'd0);
    check("reset_strobe", 32'(note_strobe), 32'd0);
    check("reset_hp", 32'(half_period), 32'd0);
    resetn = 1'b1;
    #1;
    check("read_after_reset", 32'(read_audio_in), 32'd1);

    for (int i = 0; i < 6; i++) begin
      base = strobe_total;
      play(tbl[i].p, AMP_BIG, tbl[i].nhalf, inval);
      check($sformatf("tbl%0d_code", i), 32'(note_code), 32'(tbl[i].code));
      check($sformatf("tbl%0d_valid", i), 32'(note_valid), 32'(tbl[i].valid));
      check($sformatf("tbl%0d_hp", i), 32'(half_period), 32'(tbl[i].hp));
      check($sformatf("tbl%0d_strobes", i), 32'(strobe_total - base), 32'(tbl[i].strobes));
      if (i > 0) check($sformatf("tbl%0d_valid_held", i), 32'(inval), 32'd0);
    end

    // Inside hysteresis: no crossings, lock survives until timeout
    base = strobe_total;
    for (int c = 0; c < 1800; c++) begin
      left_in = c[0] ? 32'(AMP_SMALL) : 32'(-AMP_SMALL);
      tick();
    end
    check("hyst_valid_before_to", 32'(note_valid), 32'd1);
    check("hyst_code_before_to", 32'(note_code), 32'd1);
    for (int c = 0; c < 300; c++) begin
      left_in = c[0] ? 32'(AMP_SMALL) : 32'(-AMP_SMALL);
      tick();
    end
    check("timeout_valid", 32'(note_valid), 32'd0);
    check("timeout_code", 32'(note_code), 32'd0);
    check("timeout_strobes", 32'(strobe_total - base), 32'd0);
    check("timeout_hp_kept", 32'(half_period), 32'd77);

    // Lock on code 5, reset mid-tone, relock
    base = strobe_total;
    play(190, AMP_BIG, 4, inval);
    check("relock_pre_code", 32'(note_code), 32'd5);
    check("relock_pre_valid", 32'(note_valid), 32'd1);
    check("relock_pre_strobes", 32'(strobe_total - base), 32'd1);
    resetn = 1'b0;
    left_in = pol ? 32'(AMP_BIG) : 32'(-AMP_BIG);
    tick();
    check("midreset_read", 32'(read_audio_in), 32'd0);
    check("midreset_code", 32'(note_code), 32'd0);
    check("midreset_valid", 32'(note_valid), 32'd0);
    check("midreset_hp", 32'(half_period), 32'd0);
    resetn = 1'b1;
    base = strobe_total;
    play(190, AMP_BIG, 3, inval);
    check("relock_partial_valid", 32'(note_valid), 32'd0);
    check("relock_partial_strobes", 32'(strobe_total - base), 32'd0);
    play(190, AMP_BIG, 1, inval);
    check("relock_code", 32'(note_code), 32'd5);
    check("relock_valid", 32'(note_valid), 32'd1);
    check("relock_strobes", 32'(strobe_total - base), 32'd1);
    check("relock_hp", 32'(half_period), 32'd190);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
